// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One radix-2 Booth digit: h = nonzero, d = subtract.
  typedef struct packed {
    logic h;
    logic d;
  } recode_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-2 Booth recoding cell: maps the bit pair (x(i), x(i-1)) to a digit in {-1, 0, +1}.
module booth_recode (
  input  logic xi,
  input  logic xi_1,
  output logic h,
  output logic d
);

  assign h = xi ^ xi_1;
  assign d = xi & ~xi_1;

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one recode/add/shift step per cycle, start/done handshake.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_reg, state_next;
  logic [WIDTH:0]     a_reg;
  logic [WIDTH:0]     m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               qm1_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic               rec_h, rec_d;
  recode_t            digit;
  logic [WIDTH:0]     a_sum;
  logic [WIDTH:0]     a_shift;
  logic [WIDTH-1:0]   q_shift;
  logic               load;
  logic               last_iter;

  booth_recode u_recode (
    .xi   (q_reg[0]),
    .xi_1 (qm1_reg),
    .h    (rec_h),
    .d    (rec_d)
  );

  assign digit = '{h: rec_h, d: rec_d};

  // A carries a guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    a_sum = a_reg;
    if (digit.h) begin
      a_sum = digit.d ? (a_reg - m_reg) : (a_reg + m_reg);
    end
  end

  // Arithmetic right shift of {A, Q, q_m1}; the bit leaving Q becomes the new q_m1.
  assign a_shift   = {a_sum[WIDTH], a_sum[WIDTH:1]};
  assign q_shift   = {a_sum[0], q_reg[WIDTH-1:1]};

  assign load      = start && (state_reg != RUN);
  assign last_iter = (state_reg == RUN) && (cnt_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (load) begin
      a_reg   <= '0;
      m_reg   <= {multiplicand[WIDTH-1], multiplicand};
      q_reg   <= multiplier;
      qm1_reg <= 1'b0;
      cnt_reg <= CW'(WIDTH);
    end else if (state_reg == RUN) begin
      a_reg   <= a_shift;
      q_reg   <= q_shift;
      qm1_reg <= q_reg[0];
      cnt_reg <= cnt_reg - CW'(1);
      // Captured on the final step so the product is valid throughout the DONE cycle.
      if (last_iter) begin
        product_reg <= {a_shift[WIDTH-1:0], q_shift};
      end
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and swept checks of booth_seq_mult at WIDTH=8: latency, handshake, reset abort, products.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    int mi, qi;
    mi = int'($signed(m));
    qi = int'($signed(q));
    return (2*W)'(mi * qi);
  endfunction

  // Accept one operation and follow it to its done pulse; full handshake checks when detail=1.
  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, input bit detail);
    int busy_cycles;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = ~q;
    busy_cycles  = 0;
    for (int i = 0; i < W; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cycles++;
      @(negedge clk);
    end
    if (detail) check({tag, "_busy_cycles"}, busy_cycles, W);
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_product"}, product, exp);
    if (detail) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, {busy, done}, 2'b00);
      check({tag, "_hold"}, product, exp);
    end
    $display("op %s: M=%0d Q=%0d product=%h expected=%h", tag, $signed(m), $signed(q), product, exp);
  endtask

  initial begin
    logic [W-1:0] corners [5];
    logic [W-1:0] rm, rq;
    int busy_cycles;
    corners = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, product}, 18'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, done, product}, 18'h0);

    // Directed vectors
    run_op("3x5",       8'd3,   8'd5,   16'h000F, 1'b1);
    run_op("m7x6",      8'hF9,  8'd6,   16'hFFD6, 1'b1);
    run_op("6xm7",      8'd6,   8'hF9,  16'hFFD6, 1'b1);
    run_op("m128xm128", 8'h80,  8'h80,  16'h4000, 1'b1);
    run_op("m128x127",  8'h80,  8'h7F,  16'hC080, 1'b1);

    // Start held high: re-pulses ignored, second op accepted in the DONE cycle
    @(negedge clk);
    multiplicand = 8'd3;
    multiplier   = 8'd5;
    start        = 1'b1;
    @(negedge clk);
    busy_cycles = 0;
    for (int i = 0; i < W; i++) begin
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    check("b2b_first_busy", busy_cycles, W);
    check("b2b_first_done", {busy, done}, 2'b01);
    check("b2b_first_product", product, 16'h000F);
    $display("op b2b_first: product=%h expected=%h", product, 16'h000F);
    multiplicand = 8'd2;
    multiplier   = 8'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", {busy, done}, 2'b10);
    check("b2b_product_held", product, 16'h000F);
    repeat (W) @(negedge clk);
    check("b2b_second_done", {busy, done}, 2'b01);
    check("b2b_second_product", product, 16'h0004);
    $display("op b2b_second: product=%h expected=%h", product, 16'h0004);

    // Reset mid-run aborts without a done pulse
    @(negedge clk);
    multiplicand = 8'd7;
    multiplier   = 8'd9;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {busy, done, product}, 18'h0);
    busy_cycles = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) busy_cycles++;
    end
    check("abort_no_done", busy_cycles, 0);
    run_op("after_abort", 8'd7, 8'd9, 16'h003F, 1'b1);

    // Reset has priority over start
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_over_start", {busy, done}, 2'b00);

    // Exhaustive corner set
    foreach (corners[i]) begin
      foreach (corners[j]) begin
        run_op("corner", corners[i], corners[j], ref_mul(corners[i], corners[j]), 1'b0);
      end
    end

    // Random sweep
    for (int k = 0; k < 1000; k++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      run_op("rand", rm, rq, ref_mul(rm, rq), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
